ip_call_stack: RTL and testbench
================================

# ip_call_stack

Parametrised instruction-pointer sequencer with a multi-level hardware call/return stack. It replaces the single-register return buffer and the IP up-counter in the mini-ALU datapath, so subroutines can nest up to `STACK_DEPTH` levels. It sits between the execute-stage decode (which supplies branch/call/ret strobes and the target) and the instruction ROM address input.

## Interface
- `ADDR_WIDTH`, 16: width of the instruction address.
- `STACK_DEPTH`, 4: number of return addresses held; must be ≥1.
- `RESET_VECTOR`, 0: value of `oIP` after reset.
- `DEPTH_W`, derived as clog2(`STACK_DEPTH`+1): width of `oDepth`.

Ports:
- `Clock`  in  1  single design clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high.
- `iStall`  in  1  holds all state while high; strobes are ignored.
- `iBranch`  in  1  unconditional redirect to `iTarget` (covers JMP, and BGE/BLE when taken).
- `iCall`  in  1  push return address, then redirect to `iTarget`.
- `iRet`  in  1  pop the top of stack and redirect to it.
- `iTarget`  in  `ADDR_WIDTH`  destination for branch and call.
- `oIP`  out  `ADDR_WIDTH`  registered instruction fetch address.
- `oFlush`  out  1  registered; high for one cycle after any redirect.
- `oDepth`  out  `DEPTH_W`  number of valid stack entries.
- `oFull`  out  1  `oDepth` == `STACK_DEPTH`.
- `oEmpty`  out  1  `oDepth` == 0.
- `oOverflow`  out  1  sticky; set by a call made while full.
- `oUnderflow`  out  1  sticky; set by a return made while empty.

## Operation
- **Reset.** `oIP`=`RESET_VECTOR`, `oDepth`=0, `oFlush`=0, `oOverflow`=0, `oUnderflow`=0. Stack contents are don't-care.
- **Strobe priority** (when `iStall`=0): `iRet` > `iCall` > `iBranch` > sequential.
  - Lower-priority strobes asserted in the same cycle are ignored entirely: no push, no flag.
- **Sequential.** `oIP` ← `oIP`+1, modulo 2^`ADDR_WIDTH`. All-ones wraps to 0.
- **Branch.** `oIP` ← `iTarget`; `oFlush` ← 1.
- **Call, not full.**
  - stack[`oDepth`] ← `oIP` (the post-call address, currently being fetched and about to be squashed).
  - `oDepth` ← `oDepth`+1.
  - `oIP` ← `iTarget`; `oFlush` ← 1.
- **Call while full.** The jump is still taken: `oIP` ← `iTarget`, `oFlush` ← 1. No push; `oDepth` unchanged; `oOverflow` ← 1.
- **Return, not empty.** `oIP` ← stack[`oDepth`−1]; `oDepth` ← `oDepth`−1; `oFlush` ← 1.
- **Return while empty.** Treated as a NOP: `oIP` ← `oIP`+1, `oFlush` ← 0, `oUnderflow` ← 1.
- **Stall.** `iStall`=1 freezes `oIP`, the stack, `oDepth` and the flags. `oFlush` ← 0.
- **Sticky flags.** `oOverflow` and `oUnderflow` clear only on `Reset`.
- **Reset mid-sequence.** `Reset` overrides stall and all strobes; the stack is logically emptied in one cycle.

## Timing
- Every strobe is sampled at rising edge N. `oIP`, `oDepth` and the flags reflect it after edge N.
- Redirect latency is one cycle. `oFlush`=1 during cycle N+1 tells the decode flip-flops to load NOP.
- Flush-to-flush:
  - Strobes arriving while `oFlush`=1 are still honoured.
  - Masking them is the decode stage's job, not this block's.
- `oFull` and `oEmpty` are combinational from the `oDepth` register. No output depends combinationally on any input.
- Stack read is combinational from the pointer register. Implement it as distributed RAM or registers with one write port.

## Structure
- Opcode constants (`JMP`, `CALL`, `RET`, `BGE`, `BLE`) stay in `Defintions.v`. The mini-ALU decodes them into this block's strobes.
- Add the shared constant `IP_STACK_DEPTH_DEFAULT` to `Defintions.v`.
- One sub-module, `lifo_stack`, parameters (WIDTH, DEPTH):
  - push/pop ports, top-of-stack read, depth, full, empty.
  - Push when full and pop when empty are no-ops.
- `ip_call_stack` holds the IP register, priority mux, flush register and sticky flags.

## Test plan
- **Reset + sequential.** Use `RESET_VECTOR`=0x0000. Release reset, no strobes for 5 cycles → `oIP` = 0,1,2,3,4,5; `oFlush`=0; `oEmpty`=1.
- **Nested calls.**
  - At `oIP`=3, call 0x40. At `oIP`=0x41, call 0x80.
  - Expect `oDepth`=2, with stack holding 3 and 0x41.
  - Ret → `oIP`=0x41. Ret → `oIP`=3.
  - `oFlush` pulses each time; `oDepth` ends at 0.
- **Overflow.** `STACK_DEPTH`=2.
  - Three calls to 0x10, 0x20, 0x30 → third call still lands `oIP`=0x30, with `oDepth`=2 and `oOverflow`=1.
  - Two rets return to the first two saved addresses.
- **Underflow.** Ret with an empty stack at `oIP`=7 → `oIP`=8, `oFlush`=0, `oUnderflow`=1. The flag holds until `Reset`.
- **Priority and stall.**
  - `iRet`+`iCall`+`iBranch` together with depth 1 (top 0x22) → `oIP`=0x22, `oDepth`=0, no push.
  - `iStall`=1 with `iCall` for 3 cycles → no change.
- **Wrap and mid-op reset.**
  - `ADDR_WIDTH`=4: `oIP` 0xF → 0x0.
  - `Reset` asserted at depth 3 → next cycle `oDepth`=0, `oIP`=`RESET_VECTOR`, flags clear.

Source files
------------

// File: rtl/ip_call_stack_pkg.sv
// Shared constants and strobe decode for the instruction-pointer sequencer.
// The mini-ALU decodes JMP/CALL/RET/BGE/BLE into the raw strobes that feed this decode.
package ip_call_stack_pkg;

    localparam int IP_STACK_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        OP_SEQ    = 2'd0,
        OP_BRANCH = 2'd1,
        OP_CALL   = 2'd2,
        OP_RET    = 2'd3
    } ip_op_e;

    // Return beats call beats branch; lower-priority strobes are dropped.
    function automatic ip_op_e decode_op(input logic ret, input logic call, input logic branch);
        if (ret)
            return OP_RET;
        else if (call)
            return OP_CALL;
        else if (branch)
            return OP_BRANCH;
        else
            return OP_SEQ;
    endfunction

endpackage

// File: rtl/ip_call_stack_lifo.sv
// Small register-based LIFO with a combinational top-of-stack read.
// A push when full and a pop when empty leave the stack untouched.
module lifo_stack #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   push_data,
    output logic [WIDTH-1:0]   top_data,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0]   mem_reg [DEPTH];
    logic [DEPTH_W-1:0] depth_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (depth_reg == DEPTH_W'(DEPTH));
    assign empty   = (depth_reg == '0);
    assign depth   = depth_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;

    always_ff @(posedge clk) begin
        if (srst)
            depth_reg <= '0;
        else if (do_push)
            depth_reg <= depth_reg + DEPTH_W'(1);
        else if (do_pop)
            depth_reg <= depth_reg - DEPTH_W'(1);
    end

    // Entry gi is written only when it is the next free slot; contents need no reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (depth_reg == DEPTH_W'(gi)))
                    mem_reg[gi] <= push_data;
            end
        end
    endgenerate

    always_comb begin
        top_data = mem_reg[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_reg == DEPTH_W'(i + 1))
                top_data = mem_reg[i];
        end
    end

endmodule

// File: rtl/ip_call_stack.sv
// Instruction-pointer sequencer: IP register, redirect priority, flush pulse,
// sticky overflow/underflow flags, and a nested call/return stack.
module ip_call_stack
    import ip_call_stack_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    STACK_DEPTH  = IP_STACK_DEPTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    DEPTH_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStall,
    input  logic                  iBranch,
    input  logic                  iCall,
    input  logic                  iRet,
    input  logic [ADDR_WIDTH-1:0] iTarget,
    output logic [ADDR_WIDTH-1:0] oIP,
    output logic                  oFlush,
    output logic [DEPTH_W-1:0]    oDepth,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    logic [ADDR_WIDTH-1:0] ip_reg;
    logic                  flush_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic [ADDR_WIDTH-1:0] top_data;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  push_next;
    logic                  pop_next;
    ip_op_e                op_next;

    assign op_next   = decode_op(iRet, iCall, iBranch);
    assign push_next = !iStall && (op_next == OP_CALL);
    assign pop_next  = !iStall && (op_next == OP_RET);

    // The pushed value is the address currently being fetched, i.e. the return point.
    lifo_stack #(
        .WIDTH   (ADDR_WIDTH),
        .DEPTH   (STACK_DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_stack (
        .clk       (Clock),
        .srst      (Reset),
        .push      (push_next),
        .pop       (pop_next),
        .push_data (ip_reg),
        .top_data  (top_data),
        .depth     (oDepth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ip_reg        <= RESET_VECTOR;
            flush_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (iStall) begin
            flush_reg <= 1'b0;
        end else begin
            case (op_next)
                OP_RET: begin
                    if (stack_empty) begin
                        ip_reg        <= ip_reg + ADDR_WIDTH'(1);
                        flush_reg     <= 1'b0;
                        underflow_reg <= 1'b1;
                    end else begin
                        ip_reg    <= top_data;
                        flush_reg <= 1'b1;
                    end
                end
                OP_CALL: begin
                    ip_reg    <= iTarget;
                    flush_reg <= 1'b1;
                    if (stack_full)
                        overflow_reg <= 1'b1;
                end
                OP_BRANCH: begin
                    ip_reg    <= iTarget;
                    flush_reg <= 1'b1;
                end
                default: begin
                    ip_reg    <= ip_reg + ADDR_WIDTH'(1);
                    flush_reg <= 1'b0;
                end
            endcase
        end
    end

    assign oIP        = ip_reg;
    assign oFlush     = flush_reg;
    assign oFull      = stack_full;
    assign oEmpty     = stack_empty;
    assign oOverflow  = overflow_reg;
    assign oUnderflow = underflow_reg;

endmodule

// File: tb/tb_ip_call_stack.sv
// Directed bench for ip_call_stack: three instances cover the default
// configuration, a two-deep stack, and a 4-bit address with a non-zero reset vector.
module tb_ip_call_stack;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Instance A: ADDR_WIDTH=16, STACK_DEPTH=4, RESET_VECTOR=0
    logic        a_reset, a_stall, a_branch, a_call, a_ret;
    logic [15:0] a_target, a_ip;
    logic        a_flush, a_full, a_empty, a_ovf, a_unf;
    logic [2:0]  a_depth;

    // Instance B: ADDR_WIDTH=16, STACK_DEPTH=2, RESET_VECTOR=0
    logic        b_reset, b_stall, b_branch, b_call, b_ret;
    logic [15:0] b_target, b_ip;
    logic        b_flush, b_full, b_empty, b_ovf, b_unf;
    logic [1:0]  b_depth;

    // Instance C: ADDR_WIDTH=4, STACK_DEPTH=4, RESET_VECTOR=0xD
    logic        c_reset;
    logic [3:0]  c_target, c_ip;
    logic        c_flush, c_full, c_empty, c_ovf, c_unf;
    logic [2:0]  c_depth;

    ip_call_stack #(.ADDR_WIDTH(16), .STACK_DEPTH(4), .RESET_VECTOR(16'h0000)) u_a (
        .Clock(Clock), .Reset(a_reset), .iStall(a_stall), .iBranch(a_branch),
        .iCall(a_call), .iRet(a_ret), .iTarget(a_target), .oIP(a_ip),
        .oFlush(a_flush), .oDepth(a_depth), .oFull(a_full), .oEmpty(a_empty),
        .oOverflow(a_ovf), .oUnderflow(a_unf)
    );

    ip_call_stack #(.ADDR_WIDTH(16), .STACK_DEPTH(2), .RESET_VECTOR(16'h0000)) u_b (
        .Clock(Clock), .Reset(b_reset), .iStall(b_stall), .iBranch(b_branch),
        .iCall(b_call), .iRet(b_ret), .iTarget(b_target), .oIP(b_ip),
        .oFlush(b_flush), .oDepth(b_depth), .oFull(b_full), .oEmpty(b_empty),
        .oOverflow(b_ovf), .oUnderflow(b_unf)
    );

    ip_call_stack #(.ADDR_WIDTH(4), .STACK_DEPTH(4), .RESET_VECTOR(4'hD)) u_c (
        .Clock(Clock), .Reset(c_reset), .iStall(1'b0), .iBranch(1'b0),
        .iCall(1'b0), .iRet(1'b0), .iTarget(c_target), .oIP(c_ip),
        .oFlush(c_flush), .oDepth(c_depth), .oFull(c_full), .oEmpty(c_empty),
        .oOverflow(c_ovf), .oUnderflow(c_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic a_drive(input logic ret, input logic call, input logic branch, input logic [15:0] tgt);
        a_ret = ret; a_call = call; a_branch = branch; a_target = tgt;
    endtask

    task automatic b_drive(input logic ret, input logic call, input logic [15:0] tgt);
        b_ret = ret; b_call = call; b_branch = 1'b0; b_target = tgt;
    endtask

    task automatic a_state(input string tag, input logic [15:0] ip, input logic flush,
                           input logic [2:0] depth, input logic ovf, input logic unf);
        check({tag, ".ip"}, 32'(a_ip), 32'(ip));
        check({tag, ".flush"}, 32'(a_flush), 32'(flush));
        check({tag, ".depth"}, 32'(a_depth), 32'(depth));
        check({tag, ".empty"}, 32'(a_empty), 32'(depth == 3'd0));
        check({tag, ".full"}, 32'(a_full), 32'(depth == 3'd4));
        check({tag, ".ovf"}, 32'(a_ovf), 32'(ovf));
        check({tag, ".unf"}, 32'(a_unf), 32'(unf));
        $display("[TB] A %s ip=%0h flush=%0b depth=%0d ovf=%0b unf=%0b", tag, a_ip, a_flush, a_depth, a_ovf, a_unf);
    endtask

    task automatic b_state(input string tag, input logic [15:0] ip, input logic flush,
                           input logic [1:0] depth, input logic ovf, input logic unf);
        check({tag, ".ip"}, 32'(b_ip), 32'(ip));
        check({tag, ".flush"}, 32'(b_flush), 32'(flush));
        check({tag, ".depth"}, 32'(b_depth), 32'(depth));
        check({tag, ".full"}, 32'(b_full), 32'(depth == 2'd2));
        check({tag, ".ovf"}, 32'(b_ovf), 32'(ovf));
        check({tag, ".unf"}, 32'(b_unf), 32'(unf));
        $display("[TB] B %s ip=%0h flush=%0b depth=%0d ovf=%0b unf=%0b", tag, b_ip, b_flush, b_depth, b_ovf, b_unf);
    endtask

    initial begin
        a_reset = 1'b1; a_stall = 1'b0; a_drive(0, 0, 0, 16'h0);
        b_reset = 1'b1; b_stall = 1'b0; b_drive(0, 0, 16'h0);
        c_reset = 1'b1; c_target = 4'h0;
        tick(); tick();

        // Reset state and five sequential fetches
        a_state("a_reset", 16'h0, 0, 0, 0, 0);
        a_reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            a_state($sformatf("a_seq%0d", i), 16'(i), 0, 0, 0, 0);
        end

        // Restart and run to IP=3 for the nested-call sequence
        a_reset = 1'b1; tick();
        a_state("a_rst2", 16'h0, 0, 0, 0, 0);
        a_reset = 1'b0;
        tick(); tick(); tick();
        a_state("a_at3", 16'h3, 0, 0, 0, 0);
        a_drive(0, 1, 0, 16'h0040); tick();
        a_state("a_call40", 16'h40, 1, 1, 0, 0);
        a_drive(0, 0, 0, 16'h0); tick();
        a_state("a_seq41", 16'h41, 0, 1, 0, 0);
        a_drive(0, 1, 0, 16'h0080); tick();
        a_state("a_call80", 16'h80, 1, 2, 0, 0);
        a_drive(1, 0, 0, 16'h0); tick();
        a_state("a_ret1", 16'h41, 1, 1, 0, 0);
        tick();
        a_state("a_ret2", 16'h3, 1, 0, 0, 0);

        // Underflow: return on an empty stack at IP=7 behaves as a NOP
        a_drive(0, 0, 0, 16'h0);
        tick(); tick(); tick(); tick();
        a_state("a_at7", 16'h7, 0, 0, 0, 0);
        a_drive(1, 0, 0, 16'h0); tick();
        a_state("a_underflow", 16'h8, 0, 0, 0, 1);
        a_drive(0, 0, 0, 16'h0); tick(); tick();
        a_state("a_unf_sticky", 16'hA, 0, 0, 0, 1);

        // Priority: ret beats call and branch with one entry (0x22) on the stack
        a_drive(0, 0, 1, 16'h0022); tick();
        a_state("a_br22", 16'h22, 1, 0, 0, 1);
        a_drive(0, 1, 0, 16'h0050); tick();
        a_state("a_call50", 16'h50, 1, 1, 0, 1);
        a_drive(1, 1, 1, 16'h0077); tick();
        a_state("a_prio", 16'h22, 1, 0, 0, 1);

        // Stall with a pending call freezes everything and drops flush
        a_stall = 1'b1; a_drive(0, 1, 0, 16'h0060);
        for (int i = 0; i < 3; i++) begin
            tick();
            a_state($sformatf("a_stall%0d", i), 16'h22, 0, 0, 0, 1);
        end
        a_stall = 1'b0; a_drive(0, 0, 0, 16'h0); tick();
        a_state("a_unstall", 16'h23, 0, 0, 0, 1);

        // Fill to four, pop back to three, then reset mid-sequence with strobes active
        a_drive(0, 1, 0, 16'h0100); tick();
        a_drive(0, 1, 0, 16'h0200); tick();
        a_drive(0, 1, 0, 16'h0300); tick();
        a_state("a_depth3", 16'h300, 1, 3, 0, 1);
        a_drive(0, 1, 0, 16'h0400); tick();
        a_state("a_full", 16'h400, 1, 4, 0, 1);
        a_drive(1, 0, 0, 16'h0); tick();
        a_state("a_pop300", 16'h300, 1, 3, 0, 1);
        a_reset = 1'b1; a_stall = 1'b1; a_drive(1, 1, 1, 16'h0055); tick();
        a_state("a_midreset", 16'h0, 0, 0, 0, 0);
        a_reset = 1'b0; a_stall = 1'b0; a_drive(0, 0, 0, 16'h0);

        // Instance B: overflow on a two-deep stack
        b_reset = 1'b0; tick();
        b_state("b_seq1", 16'h1, 0, 0, 0, 0);
        b_drive(0, 1, 16'h0010); tick();
        b_state("b_call10", 16'h10, 1, 1, 0, 0);
        b_drive(0, 1, 16'h0020); tick();
        b_state("b_call20", 16'h20, 1, 2, 0, 0);
        b_drive(0, 1, 16'h0030); tick();
        b_state("b_call30", 16'h30, 1, 2, 1, 0);
        b_drive(1, 0, 16'h0); tick();
        b_state("b_ret1", 16'h10, 1, 1, 1, 0);
        tick();
        b_state("b_ret2", 16'h1, 1, 0, 1, 0);
        tick();
        b_state("b_ret_empty", 16'h2, 0, 0, 1, 1);
        b_drive(0, 0, 16'h0);

        // Instance C: reset vector and 4-bit wrap
        check("c_reset.ip", 32'(c_ip), 32'h0000000D);
        check("c_reset.empty", 32'(c_empty), 32'h1);
        c_reset = 1'b0;
        tick(); check("c_seqE", 32'(c_ip), 32'h0000000E);
        tick(); check("c_seqF", 32'(c_ip), 32'h0000000F);
        tick(); check("c_wrap0", 32'(c_ip), 32'h00000000);
        check("c_wrap.flush", 32'(c_flush), 32'h0);
        tick(); check("c_seq1", 32'(c_ip), 32'h00000001);
        $display("[TB] C wrap ip=%0h flush=%0b depth=%0d", c_ip, c_flush, c_depth);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
